list_free_mgr: RTL and testbench

- Free-list manager and allocation arbiter for the linked-list node pool of N nodes, indexed by ptr_t pointers of W_PTR = $clog2(N) bits.
- After reset it links all nodes into a free list held in an internal next-pointer array.
- Serves pointer allocations to N_REQ requesters under round-robin arbitration, and accepts freed pointers back.
- Sits between pointer consumers (e.g. req_gen-style generators) and the list datapath.

---
 rtl/list_free_mgr.sv | 194 +++++++++++++++++++
 tb/tb_list_free_mgr.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_free_mgr.sv
// list_free_mgr: free-list manager and round-robin allocation arbiter for a
// linked-list node pool of N nodes.
//
// After reset the block walks the pool once, linking node i to node i+1, and
// then serves one allocation per cycle from the head of a LIFO free list.
// A free in the same cycle as a grant is forwarded straight to the winner
// (bypass) without touching the list.
//
// Optional build macro: LIST_FREE_MGR_CHECK_EN
//   When defined, an ownership bitmap tracks which pointers are out on loan.
//   A free of a pointer that is not owned (double free) is dropped and
//   raises err. When undefined, only the overflow check (free while the list
//   is already full) raises err.
//
// Handshakes:
//   alloc: a requester holds alloc_req[i] until it sees alloc_gnt[i] high in
//          the same cycle; alloc_ptr is meaningful only while |alloc_gnt.
//   free:  free_vld is accepted in any cycle where free_rdy is high; there is
//          no back-pressure other than free_rdy (low during the init sweep).
//
// state_dbg exposes the FSM state (0 = INIT, 1 = RUN) for external checkers.

module list_free_mgr #(
  parameter  int N     = 256,
  parameter  int N_REQ = 2,
  localparam int W_PTR = $clog2(N),
  localparam int W_CNT = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] alloc_req,
  output logic [N_REQ-1:0] alloc_gnt,
  output logic [W_PTR-1:0] alloc_ptr,
  input  logic             free_vld,
  input  logic [W_PTR-1:0] free_ptr,
  output logic             free_rdy,
  output logic             init_done,
  output logic             empty,
  output logic [W_CNT-1:0] count,
  output logic             err,
  output logic             state_dbg
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [W_PTR-1:0] init_idx_q;
  logic [W_PTR-1:0] head_q;
  logic [W_CNT-1:0] count_q;
  logic [RR_W-1:0]  rr_q;
  logic             err_q;
  logic [W_PTR-1:0] nxt [N];

  logic             init_last;
  logic             run;
  logic             full;
  logic             free_acc;
  logic             free_ok;
  logic             dbl_free;
  logic             grant;
  logic             bypass;
  logic             overflow;
  logic             free_push;
  logic             found;
  logic [RR_W-1:0]  winner;
  logic [RR_W-1:0]  rr_next;

  assign init_last = (init_idx_q == W_PTR'(N - 1));
  assign run       = (state_q == S_RUN) && rst;
  assign full      = (count_q == W_CNT'(N));
  assign free_acc  = run && free_vld;

`ifdef LIST_FREE_MGR_CHECK_EN
  logic [N-1:0] owned_q;

  // A free is only honoured for a pointer currently out on loan.
  assign free_ok  = free_acc && owned_q[free_ptr];
  assign dbl_free = free_acc && !owned_q[free_ptr];

  // Ownership bitmap: set on grant, cleared on accepted free; in bypass the
  // same pointer is cleared and re-set, so the later set wins.
  always_ff @(posedge clk) begin
    if (!rst || state_q == S_INIT) begin
      owned_q <= '0;
    end else begin
      if (free_push || bypass) owned_q[free_ptr] <= 1'b0;
      if (grant)               owned_q[alloc_ptr] <= 1'b1;
    end
  end
`else
  assign free_ok  = free_acc;
  assign dbl_free = 1'b0;
`endif

  // A grant may be fed by the list itself or by a same-cycle bypassed free.
  assign grant     = run && (|alloc_req) && ((count_q != '0) || free_ok);
  assign bypass    = grant && free_ok;
  assign overflow  = free_ok && !grant && full;
  assign free_push = free_ok && !grant && !full;

  // Round-robin winner: first request at or above rr_q, else first overall.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && alloc_req[j] && (RR_W'(j) >= rr_q)) begin
        found  = 1'b1;
        winner = RR_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && alloc_req[j]) begin
        found  = 1'b1;
        winner = RR_W'(j);
      end
    end
    rr_next = (winner == RR_W'(N_REQ - 1)) ? '0 : winner + RR_W'(1);
  end

  // Grant vector and pointer; bypass hands the freed pointer straight out.
  always_comb begin
    alloc_gnt = '0;
    if (grant) alloc_gnt = N_REQ'(1) << winner;
    alloc_ptr = bypass ? free_ptr : head_q;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // FSM next state: INIT sweeps once over the pool, then RUN forever.
  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_last) state_d = S_RUN;
  end

  // FSM outputs.
  always_comb begin
    init_done = run;
    free_rdy  = run;
    empty     = !rst || (count_q == '0);
    state_dbg = (state_q == S_RUN);
  end

  assign count = count_q;
  assign err   = err_q;

  // Head, count, round-robin pointer, init index and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_idx_q <= '0;
      head_q     <= '0;
      count_q    <= '0;
      rr_q       <= '0;
      err_q      <= 1'b0;
    end else if (state_q == S_INIT) begin
      init_idx_q <= init_idx_q + W_PTR'(1);
      if (init_last) begin
        head_q  <= '0;
        count_q <= W_CNT'(N);
      end
    end else begin
      if (grant) begin
        rr_q <= rr_next;
        if (!bypass) begin
          head_q  <= nxt[head_q];
          count_q <= count_q - W_CNT'(1);
        end
      end else if (free_push) begin
        head_q  <= free_ptr;
        count_q <= count_q + W_CNT'(1);
      end
      if (overflow || dbl_free) err_q <= 1'b1;
    end
  end

  // Next-pointer array: linear links during INIT, push-to-head on free.
  always_ff @(posedge clk) begin
    if (rst && state_q == S_INIT) begin
      nxt[init_idx_q] <= init_idx_q + W_PTR'(1);
    end else if (rst && free_push) begin
      nxt[free_ptr] <= head_q;
    end
  end

endmodule

// File: tb/tb_list_free_mgr.sv
// tb_list_free_mgr: self-checking bench for list_free_mgr.
// The reference model keeps the free list as a LIFO queue (front = next
// pointer handed out) plus the set of pointers currently held by requesters.

module tb_list_free_mgr;

  localparam int N     = 256;
  localparam int N_REQ = 2;
  localparam int W_PTR = 8;
  localparam int W_CNT = 9;

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] alloc_req;
  logic [N_REQ-1:0] alloc_gnt;
  logic [W_PTR-1:0] alloc_ptr;
  logic             free_vld;
  logic [W_PTR-1:0] free_ptr;
  logic             free_rdy;
  logic             init_done;
  logic             empty;
  logic [W_CNT-1:0] count;
  logic             err;
  logic             state_dbg;

  list_free_mgr #(.N(N), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_ptr (alloc_ptr),
    .free_vld  (free_vld),
    .free_ptr  (free_ptr),
    .free_rdy  (free_rdy),
    .init_done (init_done),
    .empty     (empty),
    .count     (count),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / reference model
  logic [W_PTR-1:0] exp_q[$];
  logic [W_PTR-1:0] held[$];
  bit               m_owned[N];
  int               m_rr;
  bit               m_err;

  int n_vec;
  int n_err;

  logic [N_REQ-1:0] obs_gnt, exp_gnt;
  logic [W_PTR-1:0] obs_ptr, exp_ptr;
  logic [W_CNT-1:0] obs_count;
  logic             obs_err, obs_empty;

  task automatic model_reset();
    exp_q.delete();
    held.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(W_PTR'(i));
      m_owned[i] = 1'b0;
    end
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  task automatic drop_held(input logic [W_PTR-1:0] p);
    for (int k = 0; k < held.size(); k++) begin
      if (held[k] == p) begin
        held.delete(k);
        break;
      end
    end
  endtask

  // Driver: applies one cycle of stimulus, predicts with the model, captures
  // combinational outputs at negedge and registered outputs after posedge.
  task automatic drive_cycle(input logic [N_REQ-1:0] req, input logic fv,
                             input logic [W_PTR-1:0] fp);
    bit fok, gok;
    int w, c;
    alloc_req = req;
    free_vld  = fv;
    free_ptr  = fp;
`ifdef LIST_FREE_MGR_CHECK_EN
    fok = fv && m_owned[fp];
`else
    fok = fv;
`endif
    gok     = (req != '0) && (exp_q.size() > 0 || fok);
    exp_gnt = '0;
    exp_ptr = '0;
    w       = 0;
    if (gok) begin
      w = -1;
      for (int k = 0; k < N_REQ; k++) begin
        c = (m_rr + k) % N_REQ;
        if (w < 0 && req[c]) w = c;
      end
      exp_gnt[w] = 1'b1;
      exp_ptr    = fok ? fp : exp_q[0];
    end
    @(negedge clk);
    obs_gnt = alloc_gnt;
    obs_ptr = alloc_ptr;
    @(posedge clk);
    #1;
    if (gok) begin
      if (fok) drop_held(fp);
      else void'(exp_q.pop_front());
      held.push_back(exp_ptr);
      m_owned[exp_ptr] = 1'b1;
      m_rr = (w + 1) % N_REQ;
    end else if (fv) begin
      if (!fok || exp_q.size() == N) begin
        m_err = 1'b1;
      end else begin
        exp_q.push_front(fp);
        m_owned[fp] = 1'b0;
        drop_held(fp);
      end
    end
    obs_count = count;
    obs_err   = err;
    obs_empty = empty;
    alloc_req = '0;
    free_vld  = 1'b0;
  endtask

  // Reset and wait for init without checks (used between scenarios).
  task automatic do_reset();
    int cyc;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    while (!init_done && cyc < N + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!init_done) begin
      n_vec++; n_err++;
      $display("FAIL init_timeout: init_done=%0b after %0d cycles, required 1", init_done, cyc);
    end
    model_reset();
  endtask

  task automatic test_reset();
    int cyc;
    bit gnt_bad, rdy_bad;
    alloc_req = 2'b11;
    free_vld  = 1'b1;
    free_ptr  = 8'd9;
    rst       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_vec++;
        if (alloc_gnt !== 2'b00 || init_done !== 1'b0 || empty !== 1'b1) begin
          n_err++;
          $display("FAIL reset_outputs: gnt=%b init_done=%b empty=%b, required 00/0/1", alloc_gnt, init_done, empty);
        end
      end
      @(posedge clk);
    end
    #1;
    rst     = 1'b1;
    cyc     = 0;
    gnt_bad = 1'b0;
    rdy_bad = 1'b0;
    while (!init_done && cyc < N + 20) begin
      @(negedge clk);
      if (alloc_gnt !== 2'b00) gnt_bad = 1'b1;
      if (free_rdy !== 1'b0)   rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    alloc_req = '0;
    free_vld  = 1'b0;
    n_vec++;
    if (gnt_bad || rdy_bad) begin
      n_err++;
      $display("FAIL init_quiet: gnt_seen=%0b rdy_seen=%0b during INIT, required 0/0", gnt_bad, rdy_bad);
    end
    n_vec++;
    if (cyc != N) begin
      n_err++;
      $display("FAIL init_latency: init_done after %0d cycles, required %0d", cyc, N);
    end
    n_vec++;
    if (count !== W_CNT'(N) || empty !== 1'b0 || free_rdy !== 1'b1 || err !== 1'b0) begin
      n_err++;
      $display("FAIL init_state: count=%0d empty=%b rdy=%b err=%b, required %0d/0/1/0", count, empty, free_rdy, err, N);
    end
    model_reset();
  endtask

  task automatic test_single_req();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b01, 1'b0, '0);
      n_vec++;
      if (obs_gnt !== 2'b01 || obs_ptr !== W_PTR'(i) || obs_gnt !== exp_gnt || obs_ptr !== exp_ptr) begin
        n_err++;
        $display("FAIL single_req[%0d]: gnt=%b ptr=%0d, required %b/%0d", i, obs_gnt, obs_ptr, exp_gnt, exp_ptr);
      end
    end
    n_vec++;
    if (obs_count !== W_CNT'(253)) begin
      n_err++;
      $display("FAIL single_count: count=%0d, required 253", obs_count);
    end
  endtask

  task automatic test_rr();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(2'b11, 1'b0, '0);
      n_vec++;
      if (obs_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10) || obs_gnt !== exp_gnt || obs_ptr !== exp_ptr) begin
        n_err++;
        $display("FAIL rr[%0d]: gnt=%b ptr=%0d, required %b/%0d", i, obs_gnt, obs_ptr, exp_gnt, exp_ptr);
      end
    end
  endtask

  task automatic test_free_lifo();
    drive_cycle(2'b00, 1'b1, 8'd1);
    n_vec++;
    if (obs_count !== W_CNT'(exp_q.size()) || obs_count !== W_CNT'(253)) begin
      n_err++;
      $display("FAIL lifo_free_count: count=%0d, required 253", obs_count);
    end
    drive_cycle(2'b01, 1'b0, '0);
    n_vec++;
    if (obs_gnt !== exp_gnt || obs_ptr !== 8'd1) begin
      n_err++;
      $display("FAIL lifo_alloc1: gnt=%b ptr=%0d, required %b/1", obs_gnt, obs_ptr, exp_gnt);
    end
    drive_cycle(2'b01, 1'b0, '0);
    n_vec++;
    if (obs_gnt !== exp_gnt || obs_ptr !== 8'd4 || obs_count !== W_CNT'(exp_q.size())) begin
      n_err++;
      $display("FAIL lifo_alloc2: gnt=%b ptr=%0d count=%0d, required %b/4/%0d", obs_gnt, obs_ptr, obs_count, exp_gnt, exp_q.size());
    end
  endtask

  task automatic test_bypass();
    logic [W_CNT-1:0] cnt_before;
    do_reset();
    repeat (7) drive_cycle(2'b01, 1'b0, '0);
    cnt_before = obs_count;
    drive_cycle(2'b01, 1'b1, 8'd5);
    n_vec++;
    if (obs_gnt !== exp_gnt || obs_ptr !== 8'd5 || obs_count !== cnt_before) begin
      n_err++;
      $display("FAIL bypass: gnt=%b ptr=%0d count=%0d, required %b/5/%0d", obs_gnt, obs_ptr, obs_count, exp_gnt, cnt_before);
    end
    drive_cycle(2'b01, 1'b0, '0);
    n_vec++;
    if (obs_ptr !== 8'd7 || obs_ptr !== exp_ptr) begin
      n_err++;
      $display("FAIL bypass_head: ptr=%0d, required 7", obs_ptr);
    end
  endtask

  task automatic test_empty();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < N; i++) begin
      drive_cycle(N_REQ'($urandom_range(1, 3)), 1'b0, '0);
      if (obs_gnt !== exp_gnt || obs_ptr !== exp_ptr) bad++;
    end
    n_vec++;
    if (bad != 0 || obs_empty !== 1'b1 || obs_count !== '0) begin
      n_err++;
      $display("FAIL drain: bad=%0d empty=%b count=%0d, required 0/1/0", bad, obs_empty, obs_count);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b11, 1'b0, '0);
      n_vec++;
      if (obs_gnt !== 2'b00 || obs_gnt !== exp_gnt) begin
        n_err++;
        $display("FAIL empty_stall[%0d]: gnt=%b, required 00", i, obs_gnt);
      end
    end
    drive_cycle(2'b00, 1'b1, 8'd7);
    drive_cycle(2'b11, 1'b0, '0);
    n_vec++;
    if (obs_gnt !== exp_gnt || obs_ptr !== 8'd7 || obs_empty !== 1'b1) begin
      n_err++;
      $display("FAIL empty_refill: gnt=%b ptr=%0d empty=%b, required %b/7/1", obs_gnt, obs_ptr, obs_empty, exp_gnt);
    end
    drive_cycle(2'b11, 1'b1, held[0]);
    n_vec++;
    if (obs_gnt !== exp_gnt || obs_ptr !== exp_ptr || obs_count !== '0) begin
      n_err++;
      $display("FAIL empty_bypass: gnt=%b ptr=%0d count=%0d, required %b/%0d/0", obs_gnt, obs_ptr, obs_count, exp_gnt, exp_ptr);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive_cycle(2'b00, 1'b1, W_PTR'($urandom_range(0, N - 1)));
    n_vec++;
    if (obs_err !== 1'b1 || obs_count !== W_CNT'(N) || obs_err !== m_err) begin
      n_err++;
      $display("FAIL overflow: err=%b count=%0d, required 1/%0d", obs_err, obs_count, N);
    end
    drive_cycle(2'b01, 1'b0, '0);
    n_vec++;
    if (obs_err !== 1'b1 || obs_ptr !== exp_ptr) begin
      n_err++;
      $display("FAIL err_sticky: err=%b ptr=%0d, required 1/%0d", obs_err, obs_ptr, exp_ptr);
    end
  endtask

`ifdef LIST_FREE_MGR_CHECK_EN
  task automatic test_double_free();
    do_reset();
    repeat (8) drive_cycle(2'b01, 1'b0, '0);
    drive_cycle(2'b00, 1'b1, 8'd7);
    drive_cycle(2'b00, 1'b1, 8'd7);
    n_vec++;
    if (obs_count !== W_CNT'(249) || obs_err !== 1'b1) begin
      n_err++;
      $display("FAIL double_free: count=%0d err=%b, required 249/1", obs_count, obs_err);
    end
    drive_cycle(2'b01, 1'b1, 8'd3);
    n_vec++;
    if (obs_ptr !== exp_ptr || obs_count !== W_CNT'(exp_q.size())) begin
      n_err++;
      $display("FAIL dropped_bypass: ptr=%0d count=%0d, required %0d/%0d", obs_ptr, obs_count, exp_ptr, exp_q.size());
    end
  endtask
`endif

  task automatic test_random();
    int bad;
    logic fv;
    logic [W_PTR-1:0] fp;
    do_reset();
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      fv = (held.size() > 0) && ($urandom_range(0, 2) == 0);
      fp = fv ? held[$urandom_range(0, held.size() - 1)] : '0;
      drive_cycle(N_REQ'($urandom_range(0, 3)), fv, fp);
      if (obs_gnt !== exp_gnt || (exp_gnt != '0 && obs_ptr !== exp_ptr) ||
          obs_count !== W_CNT'(exp_q.size()) || obs_err !== m_err ||
          obs_empty !== (exp_q.size() == 0)) begin
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: gnt=%b ptr=%0d count=%0d err=%b, required %b/%0d/%0d/%b", i, obs_gnt, obs_ptr, obs_count, obs_err, exp_gnt, exp_ptr, exp_q.size(), m_err);
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL random_total: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    test_reset();
    drive_cycle(2'b10, 1'b0, '0);
    n_vec++;
    if (obs_gnt !== 2'b10 || obs_ptr !== 8'd0 || obs_count !== W_CNT'(255)) begin
      n_err++;
      $display("FAIL mid_reset: gnt=%b ptr=%0d count=%0d, required 10/0/255", obs_gnt, obs_ptr, obs_count);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    alloc_req = '0;
    free_vld  = 1'b0;
    free_ptr  = '0;
    model_reset();
    test_reset();
    test_single_req();
    test_rr();
    test_free_lifo();
    test_bypass();
    test_empty();
    test_overflow();
`ifdef LIST_FREE_MGR_CHECK_EN
    test_double_free();
`endif
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
